// File: rtl/out_channel_checker_pkg.sv
// Shared types, default sizes and width helpers for the output-channel checker.
// Optional overwrite-on-full behaviour is selected with OUT_CHANNEL_CHECKER_WRAP_EN.
package out_channel_checker_pkg;

    localparam int MEM_W = 12;
    localparam int N_OUT = 16;
    localparam int N_EXP = 8;

    typedef logic [MEM_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PTR_W = $clog2(N_OUT);
    localparam int CNT_W = PTR_W + 1;

    // Index width that never collapses to zero bits for a single-entry table.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_channel_fifo.sv
// Circular word buffer with occupancy count; drops or overwrites on a full push
// depending on OUT_CHANNEL_CHECKER_WRAP_EN.
module out_channel_fifo
    import out_channel_checker_pkg::*;
#(
    parameter int DATA_W = MEM_W,
    parameter int DEPTH  = N_OUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_pop;
    logic              do_write;
    logic              displace;

    assign full   = (count == FULL_CNT);
    assign valid  = (count != '0);
    assign rdata  = valid ? mem[rd_ptr] : '0;
    assign do_pop = pop && valid;

    assign overflow = push && full && !do_pop;
`ifdef OUT_CHANNEL_CHECKER_WRAP_EN
    assign do_write = push;
`else
    assign do_write = push && (!full || do_pop);
`endif
    // A write into a full buffer without a pop pushes the oldest word out.
    assign displace = do_write && full && !do_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop || displace)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_write && !do_pop && !full)
                count <= count + CW'(1);
            else if (do_pop && !do_write)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_write)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/out_channel_checker.sv
// Buffers core output words, drains them over valid/ready and checks them against a
// loadable expected table. Macro OUT_CHANNEL_CHECKER_WRAP_EN: overwrite oldest on full.
module out_channel_checker
    import out_channel_checker_pkg::*;
#(
    parameter int MemoryElementWidth = MEM_W,
    parameter int NOut               = N_OUT,
    parameter int NExpected          = N_EXP
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 outWrite,
    input  logic [MemoryElementWidth-1:0]        outData,
    output logic                                 outFull,
    input  logic                                 programDone,
    output logic                                 drainValid,
    input  logic                                 drainReady,
    output logic [MemoryElementWidth-1:0]        drainData,
    input  logic                                 expWrite,
    input  logic [idx_w(NExpected)-1:0]          expIndex,
    input  logic [MemoryElementWidth-1:0]        expData,
    output logic                                 finished,
    output logic                                 success,
    output logic [$clog2(NExpected+1)-1:0]       mismatchIndex,
    output logic [$clog2(NExpected+1)+1-1:0]     wordCount
);

    localparam int EIW = idx_w(NExpected);
    localparam int MIW = $clog2(NExpected + 1);
    localparam int WCW = MIW + 1;
    localparam logic [WCW-1:0] NEXP_WC = WCW'(NExpected);

    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [1:0] S_DONE  = DONE;

    logic [MemoryElementWidth-1:0] expected [NExpected];
    logic [MemoryElementWidth-1:0] exp_word;
    logic [1:0]                    state;
    logic                          push;
    logic                          pop;
    logic                          ovf_evt;
    logic                          in_range;
    logic                          word_bad;
    logic                          mismatch_seen;
    logic                          overflow;

    function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
        return (&v) ? v : v + WCW'(1);
    endfunction

    assign push = outWrite && (state == S_RUN);
    assign pop  = drainValid && drainReady;

    out_channel_fifo #(
        .DATA_W (MemoryElementWidth),
        .DEPTH  (NOut)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .wdata    (outData),
        .pop      (pop),
        .full     (outFull),
        .valid    (drainValid),
        .rdata    (drainData),
        .overflow (ovf_evt)
    );

    // The expected table is configuration, so it survives reset.
    always_ff @(posedge clock) begin
        if (expWrite && (int'(expIndex) < NExpected))
            expected[expIndex] <= expData;
    end

    assign in_range = (wordCount < NEXP_WC);
    assign exp_word = expected[wordCount[EIW-1:0]];
    assign word_bad = !in_range || (drainData != exp_word);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_RUN;
            finished      <= 1'b0;
            success       <= 1'b0;
            mismatch_seen <= 1'b0;
            overflow      <= 1'b0;
            mismatchIndex <= '0;
            wordCount     <= '0;
        end else begin
            if (ovf_evt)
                overflow <= 1'b1;
            if (pop) begin
                wordCount <= sat_inc(wordCount);
                if (word_bad && !mismatch_seen) begin
                    mismatch_seen <= 1'b1;
                    mismatchIndex <= wordCount[MIW-1:0];
                end
            end
            case (state)
                S_RUN: begin
                    if (programDone)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    // Empty buffer means every word has been popped and checked.
                    if (!drainValid) begin
                        state    <= S_DONE;
                        finished <= 1'b1;
                        success  <= !mismatch_seen && (wordCount == NEXP_WC) && !overflow;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed bench for out_channel_checker at NOut=4, NExpected=2, 12-bit words.
module tb_out_channel_checker;

    localparam int W = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic          outWrite;
    logic [W-1:0]  outData;
    logic          outFull;
    logic          programDone;
    logic          drainValid;
    logic          drainReady;
    logic [W-1:0]  drainData;
    logic          expWrite;
    logic [0:0]    expIndex;
    logic [W-1:0]  expData;
    logic          finished;
    logic          success;
    logic [1:0]    mismatchIndex;
    logic [2:0]    wordCount;

    int n_asserts = 0;
    int n_fail    = 0;

    out_channel_checker #(
        .MemoryElementWidth (W),
        .NOut               (4),
        .NExpected          (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .outWrite      (outWrite),
        .outData       (outData),
        .outFull       (outFull),
        .programDone   (programDone),
        .drainValid    (drainValid),
        .drainReady    (drainReady),
        .drainData     (drainData),
        .expWrite      (expWrite),
        .expIndex      (expIndex),
        .expData       (expData),
        .finished      (finished),
        .success       (success),
        .mismatchIndex (mismatchIndex),
        .wordCount     (wordCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_asserts++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_exp(input logic [0:0] idx, input logic [W-1:0] v);
        expWrite = 1'b1;
        expIndex = idx;
        expData  = v;
        tick();
        expWrite = 1'b0;
    endtask

    task automatic write_word(input logic [W-1:0] v);
        outWrite = 1'b1;
        outData  = v;
        tick();
        outWrite = 1'b0;
    endtask

    task automatic done_pulse();
        programDone = 1'b1;
        tick();
        programDone = 1'b0;
    endtask

    task automatic wait_finished(input string tag);
        for (int i = 0; i < 30 && !finished; i++)
            tick();
        check({tag, " finished"}, finished, 1);
    endtask

    task automatic pass_case(input string tag);
        drainReady = 1'b0;
        write_word(12'd5);
        check({tag, " valid after 1st write"}, drainValid, 1);
        check({tag, " head after 1st write"}, drainData, 5);
        // Last write shares its cycle with programDone and must still land.
        outWrite    = 1'b1;
        outData     = 12'd7;
        programDone = 1'b1;
        tick();
        outWrite    = 1'b0;
        programDone = 1'b0;
        check({tag, " outFull at 2 words"}, outFull, 0);
        drainReady = 1'b1;
        check({tag, " drain 0"}, drainData, 5);
        tick();
        check({tag, " drain 1"}, drainData, 7);
        check({tag, " wordCount 1"}, wordCount, 1);
        tick();
        check({tag, " empty"}, drainValid, 0);
        check({tag, " not finished yet"}, finished, 0);
        check({tag, " wordCount 2"}, wordCount, 2);
        tick();
        check({tag, " finished"}, finished, 1);
        check({tag, " success"}, success, 1);
        check({tag, " final wordCount"}, wordCount, 2);
        check({tag, " mismatchIndex"}, mismatchIndex, 0);
        drainReady = 1'b0;
    endtask

    logic [W-1:0] bp_in [5] = '{12'd5, 12'd7, 12'd3, 12'd9, 12'd11};

    initial begin
        reset       = 1'b1;
        outWrite    = 1'b0;
        outData     = '0;
        programDone = 1'b0;
        drainReady  = 1'b0;
        expWrite    = 1'b0;
        expIndex    = '0;
        expData     = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst outFull", outFull, 0);
        check("rst drainValid", drainValid, 0);
        check("rst drainData", drainData, 0);
        check("rst finished", finished, 0);
        check("rst success", success, 0);
        check("rst mismatchIndex", mismatchIndex, 0);
        check("rst wordCount", wordCount, 0);

        load_exp(1'b0, 12'd5);
        load_exp(1'b1, 12'd7);

        pass_case("pass");

        // Second word differs from the table.
        do_reset();
        write_word(12'd5);
        write_word(12'd9);
        done_pulse();
        drainReady = 1'b1;
        wait_finished("mism");
        check("mism success", success, 0);
        check("mism mismatchIndex", mismatchIndex, 1);
        check("mism wordCount", wordCount, 2);
        drainReady = 1'b0;

        // One word beyond the table.
        do_reset();
        write_word(12'd5);
        write_word(12'd7);
        write_word(12'd3);
        done_pulse();
        drainReady = 1'b1;
        wait_finished("extra");
        check("extra success", success, 0);
        check("extra mismatchIndex", mismatchIndex, 2);
        check("extra wordCount", wordCount, 3);
        drainReady = 1'b0;

        // Short output; the write during FLUSH must be ignored.
        do_reset();
        write_word(12'd5);
        done_pulse();
        write_word(12'd7);
        drainReady = 1'b1;
        wait_finished("short");
        check("short success", success, 0);
        check("short wordCount", wordCount, 1);
        drainReady = 1'b0;

        // Backpressure: fill, then one more write while full.
        do_reset();
        for (int i = 0; i < 3; i++)
            write_word(bp_in[i]);
        check("bp not full at 3", outFull, 0);
        write_word(bp_in[3]);
        check("bp full at 4", outFull, 1);
        write_word(bp_in[4]);
        check("bp still full", outFull, 1);
        done_pulse();
        drainReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef OUT_CHANNEL_CHECKER_WRAP_EN
            check($sformatf("bp drain %0d", i), drainData, bp_in[i+1]);
`else
            check($sformatf("bp drain %0d", i), drainData, bp_in[i]);
`endif
            tick();
        end
        check("bp empty", drainValid, 0);
        wait_finished("bp");
        check("bp success", success, 0);
        check("bp wordCount", wordCount, 4);
        drainReady = 1'b0;

        // Push and pop together while full.
        do_reset();
        for (int i = 1; i <= 4; i++)
            write_word(W'(i));
        check("pp full", outFull, 1);
        check("pp head before", drainData, 1);
        outWrite   = 1'b1;
        outData    = 12'd6;
        drainReady = 1'b1;
        tick();
        outWrite = 1'b0;
        check("pp still full", outFull, 1);
        check("pp drain 0", drainData, 2);
        tick();
        check("pp drain 1", drainData, 3);
        tick();
        check("pp drain 2", drainData, 4);
        tick();
        check("pp drain 3", drainData, 6);
        tick();
        check("pp empty", drainValid, 0);
        drainReady = 1'b0;

        // Reset while flushing two buffered words.
        do_reset();
        write_word(12'd5);
        write_word(12'd7);
        done_pulse();
        check("rf buffered", drainValid, 1);
        do_reset();
        check("rf drainValid", drainValid, 0);
        check("rf drainData", drainData, 0);
        check("rf finished", finished, 0);
        check("rf wordCount", wordCount, 0);
        check("rf outFull", outFull, 0);
        pass_case("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
